// File: rtl/sparc_exu_ccr_file.sv
// Per-thread condition-code register file with E/M/W bypass, a long-latency (W2) write port,
// a TLU restore path and a one-entry-per-thread buffer for W writes that collide with W2.
module sparc_exu_ccr_file #(
  parameter int NTHR = 4,
  parameter int TIDW = 2,
  parameter int CCW  = 8
) (
  input  logic                 clk,
  input  logic                 arst_l,
  input  logic [TIDW-1:0]      tid_d,
  input  logic                 setcc_d,
  input  logic                 kill_e,
  input  logic [CCW-1:0]       alu_cc_e,
  input  logic                 restore_m,
  input  logic [CCW-1:0]       restore_cc_m,
  input  logic                 inst_vld_w,
  input  logic                 flush_w,
  input  logic                 wrccr_w,
  input  logic [CCW-1:0]       wrccr_data_w,
  input  logic                 lat_vld_w2,
  input  logic [TIDW-1:0]      lat_tid_w2,
  input  logic [CCW-1:0]       lat_cc_w2,
  output logic [CCW-1:0]       cc_d,
  output logic [NTHR*CCW-1:0]  ccr_all,
  output logic [NTHR-1:0]      pend_vld
);

  logic            r_setcc_e, r_setcc_m, r_setcc_w;
  logic [TIDW-1:0] r_tid_e, r_tid_m, r_tid_w;
  logic [CCW-1:0]  r_cc_m, r_cc_w;
  logic [CCW-1:0]  r_ccr  [NTHR];
  logic [CCW-1:0]  r_pend [NTHR];
  logic [NTHR-1:0] r_pend_vld;

  logic            w_setcc_e_eff;
  logic            w_setcc_m_eff;
  logic [CCW-1:0]  w_cc_m;
  logic            w_commit_w;
  logic [CCW-1:0]  w_wdata_w;
  logic [NTHR-1:0] w_c1, w_c2;
  logic [CCW-1:0]  w_sel_ccr, w_sel_pend;
  logic            w_sel_pvld;

  assign w_setcc_e_eff = r_setcc_e & ~kill_e;
  assign w_setcc_m_eff = r_setcc_m | restore_m;
  assign w_cc_m        = restore_m ? restore_cc_m : r_cc_m;
  assign w_commit_w    = inst_vld_w & ~flush_w & (r_setcc_w | wrccr_w);
  assign w_wdata_w     = wrccr_w ? wrccr_data_w : r_cc_w;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_setcc_e <= 1'b0;
      r_setcc_m <= 1'b0;
      r_setcc_w <= 1'b0;
      r_tid_e   <= '0;
      r_tid_m   <= '0;
      r_tid_w   <= '0;
      r_cc_m    <= '0;
      r_cc_w    <= '0;
    end else begin
      r_setcc_e <= setcc_d;
      r_setcc_m <= w_setcc_e_eff;
      r_setcc_w <= w_setcc_m_eff;
      r_tid_e   <= tid_d;
      r_tid_m   <= r_tid_e;
      r_tid_w   <= r_tid_m;
      r_cc_m    <= alu_cc_e;
      r_cc_w    <= w_cc_m;
    end
  end

  always_comb begin
    w_c1 = '0;
    w_c2 = '0;
    for (int t = 0; t < NTHR; t++) begin
      w_c2[t] = lat_vld_w2 & (lat_tid_w2 == TIDW'(t));
      w_c1[t] = w_commit_w & (r_tid_w == TIDW'(t));
    end
  end

  // W2 is older than W: on a same-thread collision W2 lands now and the W write waits in pend.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int t = 0; t < NTHR; t++) begin
        r_ccr[t]  <= '0;
        r_pend[t] <= '0;
      end
      r_pend_vld <= '0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        if (w_c2[t]) begin
          r_ccr[t] <= lat_cc_w2;
          if (w_c1[t]) begin
            r_pend[t]     <= w_wdata_w;
            r_pend_vld[t] <= 1'b1;
          end
        end else if (w_c1[t]) begin
          r_ccr[t]      <= w_wdata_w;
          r_pend_vld[t] <= 1'b0;
        end else if (r_pend_vld[t]) begin
          r_ccr[t]      <= r_pend[t];
          r_pend_vld[t] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sel_ccr  = '0;
    w_sel_pend = '0;
    w_sel_pvld = 1'b0;
    for (int t = 0; t < NTHR; t++) begin
      if (tid_d == TIDW'(t)) begin
        w_sel_ccr  = r_ccr[t];
        w_sel_pend = r_pend[t];
        w_sel_pvld = r_pend_vld[t];
      end
    end
  end

  always_comb begin
    cc_d = w_sel_ccr;
    if (w_setcc_e_eff && r_tid_e == tid_d)
      cc_d = alu_cc_e;
    else if (w_setcc_m_eff && r_tid_m == tid_d)
      cc_d = w_cc_m;
    else if (w_commit_w && r_tid_w == tid_d)
      cc_d = w_wdata_w;
    else if (w_sel_pvld)
      cc_d = w_sel_pend;
  end

  always_comb begin
    ccr_all = '0;
    for (int t = 0; t < NTHR; t++)
      ccr_all[t*CCW +: CCW] = r_ccr[t];
  end

  assign pend_vld = r_pend_vld;

endmodule

// File: tb/tb_sparc_exu_ccr_file.sv
// Bench for sparc_exu_ccr_file: directed scenarios plus random traffic against an
// instruction-record reference model; two extra instances cover other parameter sets.
module tb_sparc_exu_ccr_file;

  logic        clk = 1'b0;
  logic        arst_l = 1'b0;
  logic [1:0]  tid_d;
  logic        setcc_d, kill_e, restore_m, inst_vld_w, flush_w, wrccr_w, lat_vld_w2;
  logic [7:0]  alu_cc_e, restore_cc_m, wrccr_data_w, lat_cc_w2;
  logic [1:0]  lat_tid_w2;
  logic [7:0]  cc_d;
  logic [31:0] ccr_all;
  logic [3:0]  pend_vld;

  logic [2:0]  s8_tid_d = '0, s8_lat_tid = '0;
  logic        s8_setcc_d = 1'b0, s8_inst_vld = 1'b0, s8_lat_vld = 1'b0;
  logic [3:0]  s8_alu = '0, s8_lat_cc = '0, s8_cc_d;
  logic [31:0] s8_ccr_all;
  logic [7:0]  s8_pend;

  logic        s1_setcc_d = 1'b0, s1_inst_vld = 1'b0, s1_lat_vld = 1'b0;
  logic [7:0]  s1_alu = '0, s1_lat_cc = '0, s1_cc_d, s1_ccr_all;
  logic [0:0]  s1_pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sparc_exu_ccr_file #(.NTHR(4), .TIDW(2), .CCW(8)) dut (
    .clk(clk), .arst_l(arst_l), .tid_d(tid_d), .setcc_d(setcc_d), .kill_e(kill_e),
    .alu_cc_e(alu_cc_e), .restore_m(restore_m), .restore_cc_m(restore_cc_m),
    .inst_vld_w(inst_vld_w), .flush_w(flush_w), .wrccr_w(wrccr_w), .wrccr_data_w(wrccr_data_w),
    .lat_vld_w2(lat_vld_w2), .lat_tid_w2(lat_tid_w2), .lat_cc_w2(lat_cc_w2),
    .cc_d(cc_d), .ccr_all(ccr_all), .pend_vld(pend_vld));

  sparc_exu_ccr_file #(.NTHR(8), .TIDW(3), .CCW(4)) dut8 (
    .clk(clk), .arst_l(arst_l), .tid_d(s8_tid_d), .setcc_d(s8_setcc_d), .kill_e(1'b0),
    .alu_cc_e(s8_alu), .restore_m(1'b0), .restore_cc_m(4'h0),
    .inst_vld_w(s8_inst_vld), .flush_w(1'b0), .wrccr_w(1'b0), .wrccr_data_w(4'h0),
    .lat_vld_w2(s8_lat_vld), .lat_tid_w2(s8_lat_tid), .lat_cc_w2(s8_lat_cc),
    .cc_d(s8_cc_d), .ccr_all(s8_ccr_all), .pend_vld(s8_pend));

  sparc_exu_ccr_file #(.NTHR(1), .TIDW(1), .CCW(8)) dut1 (
    .clk(clk), .arst_l(arst_l), .tid_d(1'b0), .setcc_d(s1_setcc_d), .kill_e(1'b0),
    .alu_cc_e(s1_alu), .restore_m(1'b0), .restore_cc_m(8'h00),
    .inst_vld_w(s1_inst_vld), .flush_w(1'b0), .wrccr_w(1'b0), .wrccr_data_w(8'h00),
    .lat_vld_w2(s1_lat_vld), .lat_tid_w2(1'b0), .lat_cc_w2(s1_lat_cc),
    .cc_d(s1_cc_d), .ccr_all(s1_ccr_all), .pend_vld(s1_pend));

  // Reference model: one record per in-flight instruction, plus architectural/pending state.
  typedef struct packed {
    logic [1:0] tid;
    logic       setcc;
    logic [7:0] cc;
  } rec_t;

  rec_t     p_e, p_m, p_w;
  bit [7:0] m_ccr  [4];
  bit [7:0] m_pend [4];
  bit       m_pvld [4];

  function automatic bit m_commit();
    return inst_vld_w && !flush_w && (p_w.setcc || wrccr_w);
  endfunction

  function automatic logic [7:0] m_wdata();
    return wrccr_w ? wrccr_data_w : p_w.cc;
  endfunction

  function automatic logic [7:0] exp_ccd();
    if (p_e.setcc && !kill_e && p_e.tid == tid_d) return alu_cc_e;
    if ((p_m.setcc || restore_m) && p_m.tid == tid_d) return restore_m ? restore_cc_m : p_m.cc;
    if (m_commit() && p_w.tid == tid_d) return m_wdata();
    if (m_pvld[tid_d]) return m_pend[tid_d];
    return m_ccr[tid_d];
  endfunction

  function automatic logic [31:0] exp_all();
    logic [31:0] v;
    for (int t = 0; t < 4; t++) v[t*8 +: 8] = m_ccr[t];
    return v;
  endfunction

  function automatic logic [3:0] exp_pvld();
    logic [3:0] v;
    for (int t = 0; t < 4; t++) v[t] = m_pvld[t];
    return v;
  endfunction

  task automatic model_clear();
    p_e = '0; p_m = '0; p_w = '0;
    for (int t = 0; t < 4; t++) begin
      m_ccr[t] = '0; m_pend[t] = '0; m_pvld[t] = 1'b0;
    end
  endtask

  task automatic idle();
    tid_d = '0; setcc_d = 0; kill_e = 0; alu_cc_e = '0; restore_m = 0; restore_cc_m = '0;
    inst_vld_w = 0; flush_w = 0; wrccr_w = 0; wrccr_data_w = '0;
    lat_vld_w2 = 0; lat_tid_w2 = '0; lat_cc_w2 = '0;
  endtask

  // Clock edge for DUT and model together; leaves time at edge+1.
  task automatic step();
    bit         cm;
    logic [7:0] wd;
    @(posedge clk);
    cm = m_commit();
    wd = m_wdata();
    for (int t = 0; t < 4; t++) begin
      bit c2, c1;
      c2 = lat_vld_w2 && lat_tid_w2 == 2'(t);
      c1 = cm && p_w.tid == 2'(t);
      if (c2) begin
        m_ccr[t] = lat_cc_w2;
        if (c1) begin m_pend[t] = wd; m_pvld[t] = 1'b1; end
      end else if (c1) begin
        m_ccr[t] = wd; m_pvld[t] = 1'b0;
      end else if (m_pvld[t]) begin
        m_ccr[t] = m_pend[t]; m_pvld[t] = 1'b0;
      end
    end
    p_w.tid = p_m.tid; p_w.setcc = p_m.setcc | restore_m; p_w.cc = restore_m ? restore_cc_m : p_m.cc;
    p_m.tid = p_e.tid; p_m.setcc = p_e.setcc & ~kill_e;   p_m.cc = alu_cc_e;
    p_e.tid = tid_d;   p_e.setcc = setcc_d;                 p_e.cc = '0;
    #1;
  endtask

  task automatic test_reset();
    arst_l = 1'b0;
    idle();
    model_clear();
    @(posedge clk); #1;
    n_checks++; if (ccr_all !== 32'h0) begin n_errors++; $display("FAIL reset_ccr_all got %h exp 0", ccr_all); end
    n_checks++; if (pend_vld !== 4'h0) begin n_errors++; $display("FAIL reset_pend_vld got %b exp 0", pend_vld); end
    for (int t = 0; t < 4; t++) begin
      tid_d = 2'(t); #1;
      n_checks++; if (cc_d !== 8'h0) begin n_errors++; $display("FAIL reset_cc_d tid %0d got %h exp 0", t, cc_d); end
    end
    tid_d = '0;
    @(negedge clk) arst_l = 1'b1;
  endtask

  task automatic test_bypass();
    idle(); tid_d = 2; setcc_d = 1; step();
    setcc_d = 0; alu_cc_e = 8'h5A; #1;
    n_checks++; if (cc_d !== 8'h5A) begin n_errors++; $display("FAIL bypass_e got %h exp 5a", cc_d); end
    step(); alu_cc_e = 8'h00; #1;
    n_checks++; if (cc_d !== 8'h5A) begin n_errors++; $display("FAIL bypass_m got %h exp 5a", cc_d); end
    step(); inst_vld_w = 1; #1;
    n_checks++; if (cc_d !== 8'h5A) begin n_errors++; $display("FAIL bypass_w got %h exp 5a", cc_d); end
    step(); inst_vld_w = 0; #1;
    n_checks++; if (ccr_all !== 32'h005A0000) begin n_errors++; $display("FAIL bypass_ccr got %h exp 005a0000", ccr_all); end
  endtask

  task automatic test_kill_flush();
    idle();
    for (int t = 0; t < 4; t++) begin
      lat_vld_w2 = 1; lat_tid_w2 = 2'(t); lat_cc_w2 = 8'h11; step();
    end
    lat_vld_w2 = 0; #1;
    n_checks++; if (ccr_all !== 32'h11111111) begin n_errors++; $display("FAIL prewrite got %h exp 11111111", ccr_all); end
    tid_d = 0; setcc_d = 1; step();
    setcc_d = 0; alu_cc_e = 8'hFF; kill_e = 1; #1;
    n_checks++; if (cc_d !== 8'h11) begin n_errors++; $display("FAIL kill_bypass_e got %h exp 11", cc_d); end
    step(); kill_e = 0; alu_cc_e = 0; step(); inst_vld_w = 1; #1;
    n_checks++; if (cc_d !== 8'h11) begin n_errors++; $display("FAIL kill_bypass_w got %h exp 11", cc_d); end
    step(); inst_vld_w = 0; #1;
    n_checks++; if (ccr_all !== 32'h11111111) begin n_errors++; $display("FAIL kill_ccr got %h exp 11111111", ccr_all); end
    tid_d = 1; setcc_d = 1; step();
    setcc_d = 0; alu_cc_e = 8'hEE; step(); alu_cc_e = 0; step();
    inst_vld_w = 1; flush_w = 1; #1;
    n_checks++; if (cc_d !== 8'h11) begin n_errors++; $display("FAIL flush_bypass got %h exp 11", cc_d); end
    step(); inst_vld_w = 0; flush_w = 0; #1;
    n_checks++; if (ccr_all[15:8] !== 8'h11) begin n_errors++; $display("FAIL flush_ccr got %h exp 11", ccr_all[15:8]); end
  endtask

  task automatic test_wrccr();
    idle(); tid_d = 1; step(); step(); step();
    wrccr_w = 1; wrccr_data_w = 8'hC3; inst_vld_w = 1; #1;
    n_checks++; if (cc_d !== 8'hC3) begin n_errors++; $display("FAIL wrccr_bypass got %h exp c3", cc_d); end
    step(); idle(); #1;
    n_checks++; if (ccr_all[15:8] !== 8'hC3) begin n_errors++; $display("FAIL wrccr_ccr got %h exp c3", ccr_all[15:8]); end
  endtask

  // Leaves a W(tid0, AA) vs W2(tid0, 55) collision just after its edge.
  task automatic make_collision();
    idle(); tid_d = 0; setcc_d = 1; step();
    setcc_d = 0; alu_cc_e = 8'hAA; step(); alu_cc_e = 0; step();
    inst_vld_w = 1; lat_vld_w2 = 1; lat_tid_w2 = 0; lat_cc_w2 = 8'h55; step();
    inst_vld_w = 0; lat_vld_w2 = 0; #1;
  endtask

  task automatic test_collision();
    make_collision();
    n_checks++; if (ccr_all[7:0] !== 8'h55) begin n_errors++; $display("FAIL coll_ccr_n1 got %h exp 55", ccr_all[7:0]); end
    n_checks++; if (pend_vld !== 4'b0001) begin n_errors++; $display("FAIL coll_pend_n1 got %b exp 0001", pend_vld); end
    n_checks++; if (cc_d !== 8'hAA) begin n_errors++; $display("FAIL coll_cc_d got %h exp aa", cc_d); end
    step();
    n_checks++; if (ccr_all[7:0] !== 8'hAA) begin n_errors++; $display("FAIL coll_ccr_n2 got %h exp aa", ccr_all[7:0]); end
    n_checks++; if (pend_vld !== 4'b0000) begin n_errors++; $display("FAIL coll_pend_n2 got %b exp 0000", pend_vld); end
    make_collision();
    lat_vld_w2 = 1; lat_tid_w2 = 0; lat_cc_w2 = 8'h66; step(); lat_vld_w2 = 0; #1;
    n_checks++; if (ccr_all[7:0] !== 8'h66 || pend_vld !== 4'b0001) begin
      n_errors++; $display("FAIL coll2_n2 got ccr %h pend %b exp 66 0001", ccr_all[7:0], pend_vld); end
    step();
    n_checks++; if (ccr_all[7:0] !== 8'hAA || pend_vld !== 4'b0000) begin
      n_errors++; $display("FAIL coll2_n3 got ccr %h pend %b exp aa 0000", ccr_all[7:0], pend_vld); end
  endtask

  task automatic test_supersede();
    idle(); tid_d = 3; setcc_d = 1; step();
    alu_cc_e = 8'h01; step();
    setcc_d = 0; alu_cc_e = 8'h02; step();
    alu_cc_e = 0; inst_vld_w = 1; lat_vld_w2 = 1; lat_tid_w2 = 3; lat_cc_w2 = 8'h77; step();
    lat_vld_w2 = 0; #1;
    n_checks++; if (pend_vld !== 4'b1000 || ccr_all[31:24] !== 8'h77) begin
      n_errors++; $display("FAIL sup_pending got pend %b ccr3 %h exp 1000 77", pend_vld, ccr_all[31:24]); end
    n_checks++; if (cc_d !== 8'h02) begin n_errors++; $display("FAIL sup_bypass got %h exp 02", cc_d); end
    step(); inst_vld_w = 0; #1;
    n_checks++; if (ccr_all[31:24] !== 8'h02 || pend_vld !== 4'b0000) begin
      n_errors++; $display("FAIL sup_retire got ccr3 %h pend %b exp 02 0000", ccr_all[31:24], pend_vld); end
    step();
    n_checks++; if (ccr_all[31:24] !== 8'h02) begin n_errors++; $display("FAIL sup_stale got %h exp 02", ccr_all[31:24]); end
  endtask

  task automatic test_restore();
    idle(); tid_d = 1; setcc_d = 1; step();
    setcc_d = 0; alu_cc_e = 8'hF0; step();
    alu_cc_e = 0; restore_m = 1; restore_cc_m = 8'h3C; #1;
    n_checks++; if (cc_d !== 8'h3C) begin n_errors++; $display("FAIL restore_m_bypass got %h exp 3c", cc_d); end
    step(); restore_m = 0; inst_vld_w = 1; #1;
    n_checks++; if (cc_d !== 8'h3C) begin n_errors++; $display("FAIL restore_w_bypass got %h exp 3c", cc_d); end
    step(); inst_vld_w = 0; #1;
    n_checks++; if (ccr_all[15:8] !== 8'h3C) begin n_errors++; $display("FAIL restore_ccr got %h exp 3c", ccr_all[15:8]); end
  endtask

  task automatic test_reset_mid();
    make_collision();
    n_checks++; if (pend_vld !== 4'b0001) begin n_errors++; $display("FAIL rstmid_pre got %b exp 0001", pend_vld); end
    arst_l = 1'b0; #1;
    n_checks++; if (pend_vld !== 4'b0 || ccr_all !== 32'h0 || cc_d !== 8'h0) begin
      n_errors++; $display("FAIL rstmid got pend %b ccr %h cc_d %h exp 0", pend_vld, ccr_all, cc_d); end
    model_clear(); idle();
    @(negedge clk) arst_l = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      tid_d        = 2'($urandom_range(3, 0));
      setcc_d      = 1'($urandom_range(1, 0));
      kill_e       = ($urandom_range(3, 0) == 0);
      alu_cc_e     = 8'($urandom);
      restore_m    = ($urandom_range(3, 0) == 0);
      restore_cc_m = 8'($urandom);
      inst_vld_w   = 1'($urandom_range(1, 0));
      flush_w      = ($urandom_range(3, 0) == 0);
      wrccr_w      = ($urandom_range(7, 0) == 0);
      wrccr_data_w = 8'($urandom);
      lat_vld_w2   = ($urandom_range(2, 0) == 0);
      lat_tid_w2   = 2'($urandom_range(3, 0));
      lat_cc_w2    = 8'($urandom);
      #1;
      n_checks++; if (cc_d !== exp_ccd()) begin
        n_errors++; $display("FAIL rand_cc_d iter %0d got %h exp %h", i, cc_d, exp_ccd()); end
      step();
      n_checks++; if (ccr_all !== exp_all() || pend_vld !== exp_pvld()) begin
        n_errors++; $display("FAIL rand_state iter %0d got %h/%b exp %h/%b", i, ccr_all, pend_vld, exp_all(), exp_pvld()); end
    end
    idle();
  endtask

  task automatic test_sweep8();
    s8_tid_d = 5; s8_setcc_d = 1; @(posedge clk); #1;
    s8_setcc_d = 0; s8_alu = 4'hA; @(posedge clk); #1;
    s8_alu = 0; @(posedge clk); #1;
    s8_inst_vld = 1; s8_lat_vld = 1; s8_lat_tid = 5; s8_lat_cc = 4'h5; @(posedge clk); #1;
    s8_inst_vld = 0; s8_lat_vld = 0; #1;
    n_checks++; if (s8_ccr_all !== 32'h0050_0000 || s8_pend !== 8'h20 || s8_cc_d !== 4'hA) begin
      n_errors++; $display("FAIL sweep8_n1 got %h/%b/%h exp 00500000/00100000/a", s8_ccr_all, s8_pend, s8_cc_d); end
    @(posedge clk); #1;
    n_checks++; if (s8_ccr_all !== 32'h00A0_0000 || s8_pend !== 8'h00) begin
      n_errors++; $display("FAIL sweep8_n2 got %h/%b exp 00a00000/0", s8_ccr_all, s8_pend); end
  endtask

  task automatic test_sweep1();
    s1_setcc_d = 1; @(posedge clk); #1;
    s1_setcc_d = 0; s1_alu = 8'hAA; @(posedge clk); #1;
    s1_alu = 0; @(posedge clk); #1;
    s1_inst_vld = 1; s1_lat_vld = 1; s1_lat_cc = 8'h55; @(posedge clk); #1;
    s1_inst_vld = 0; s1_lat_vld = 0; #1;
    n_checks++; if (s1_ccr_all !== 8'h55 || s1_pend !== 1'b1 || s1_cc_d !== 8'hAA) begin
      n_errors++; $display("FAIL sweep1_n1 got %h/%b/%h exp 55/1/aa", s1_ccr_all, s1_pend, s1_cc_d); end
    @(posedge clk); #1;
    n_checks++; if (s1_ccr_all !== 8'hAA || s1_pend !== 1'b0) begin
      n_errors++; $display("FAIL sweep1_n2 got %h/%b exp aa/0", s1_ccr_all, s1_pend); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_kill_flush();
    test_wrccr();
    test_collision();
    test_supersede();
    test_restore();
    test_reset_mid();
    test_random();
    test_sweep8();
    test_sweep1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
